// File: rtl/bsg_vanilla_pkg.sv
// bsg_vanilla_pkg
//   Shared vanilla-core types. Holds the SIMD load/store sequencer state
//   encoding, the per-beat record it presents to DMEM / network TX, and a
//   small width helper used for derived parameters.
//   No ports (package).
package bsg_vanilla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } lsu_simd_state_e;

    // Lane id field is sized for the widest sequencer we expect to build;
    // each instance narrows it to its own lane_id_width_lp.
    localparam int unsigned lsu_simd_lane_id_width_gp = 8;

    typedef struct packed {
        logic                                 w;
        logic [31:0]                          addr;
        logic [31:0]                          data;
        logic [3:0]                           mask;
        logic [lsu_simd_lane_id_width_gp-1:0] lane_id;
    } lsu_simd_beat_s;

    // clog2 that never returns 0, so a 1-lane build still gets a 1-bit id.
    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// lsu_store_align
//   Combinational store formatter: replicates the element across the word
//   and builds the byte mask from the element size and the byte offset.
//   Shared by the SIMD sequencer and the scalar store path.
//   Ports:
//     is_byte_op_i   byte element (wins over is_hex_op_i)
//     is_hex_op_i    halfword element
//     byte_offset_i  address bits [1:0] of the element
//     data_i         raw lane data
//     data_o         replicated store data
//     mask_o         byte-enable mask
module lsu_store_align
    import bsg_vanilla_pkg::*;
(
    input  logic        is_byte_op_i,
    input  logic        is_hex_op_i,
    input  logic [1:0]  byte_offset_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [3:0]  mask_o
);

    always_comb begin
        data_o = data_i;
        mask_o = 4'b1111;
        if (is_byte_op_i) begin
            data_o = {4{data_i[7:0]}};
            mask_o = 4'b0001 << byte_offset_i;
        end else if (is_hex_op_i) begin
            data_o = {2{data_i[15:0]}};
            mask_o = {{2{byte_offset_i[1]}}, {2{~byte_offset_i[1]}}};
        end
    end

endmodule

// File: rtl/lsu_simd_seq.sv
// lsu_simd_seq
//   Load/store sequencer for multi-lane (SIMD) memory ops. Latches one
//   request covering up to lanes_p word-strided elements, then issues one
//   beat per cycle (lowest pending lane first) to either local DMEM or the
//   remote network, chosen per lane by address. done_o pulses once when
//   every enabled lane has been accepted.
//   Ports:
//     clk_i, reset_i                  clock, synchronous active-high reset
//     v_i / ready_o                   request handshake
//     is_store_i, is_byte_op_i,
//     is_hex_op_i, lane_en_i, rs1_i,
//     offset_i, data_i, rd_i          request fields
//     dmem_*                          local beat (word address) + ready
//     remote_*                        remote beat (byte address) + ready
//     lane_id_o                       lane of the current beat
//     rd_o                            latched destination register
//     busy_o, done_o                  issuing / one-cycle completion
module lsu_simd_seq
    import bsg_vanilla_pkg::*;
#(
    parameter  int unsigned data_width_p       = 32,
    parameter  int unsigned dmem_size_p        = 1024,
    parameter  int unsigned lanes_p            = 4,
    localparam int unsigned dmem_addr_width_lp = $clog2(dmem_size_p),
    localparam int unsigned mask_width_lp      = data_width_p / 8,
    localparam int unsigned lane_id_width_lp   = safe_clog2(lanes_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            v_i,
    output logic                            ready_o,
    input  logic                            is_store_i,
    input  logic                            is_byte_op_i,
    input  logic                            is_hex_op_i,
    input  logic [lanes_p-1:0]              lane_en_i,
    input  logic [31:0]                     rs1_i,
    input  logic [11:0]                     offset_i,
    input  logic [lanes_p*data_width_p-1:0] data_i,
    input  logic [4:0]                      rd_i,
    output logic                            dmem_v_o,
    input  logic                            dmem_ready_i,
    output logic                            dmem_w_o,
    output logic [dmem_addr_width_lp-1:0]   dmem_addr_o,
    output logic [data_width_p-1:0]         dmem_data_o,
    output logic [mask_width_lp-1:0]        dmem_mask_o,
    output logic                            remote_v_o,
    input  logic                            remote_ready_i,
    output logic                            remote_w_o,
    output logic [31:0]                     remote_addr_o,
    output logic [data_width_p-1:0]         remote_data_o,
    output logic [mask_width_lp-1:0]        remote_mask_o,
    output logic [lane_id_width_lp-1:0]     lane_id_o,
    output logic [4:0]                      rd_o,
    output logic                            busy_o,
    output logic                            done_o
);

    lsu_simd_state_e             state_r, state_n;
    logic [31:0]                 base_r;
    logic                        is_store_r, is_byte_r, is_hex_r;
    logic [data_width_p-1:0]     lane_data_r [lanes_p];
    logic [4:0]                  rd_r;
    logic [lanes_p-1:0]          pending_r, pending_clr;
    logic [lane_id_width_lp-1:0] lane_sel;
    logic [31:0]                 lane_addr;
    logic                        is_local, fire;
    logic [31:0]                 st_data;
    logic [3:0]                  st_mask;
    lsu_simd_beat_s              beat;
    logic                        unused_lane_id_hi;

    function automatic logic [lane_id_width_lp-1:0] lowest_set(input logic [lanes_p-1:0] v);
        logic found;
        lowest_set = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < lanes_p; i++) begin
            if (v[i] && !found) begin
                lowest_set = lane_id_width_lp'(i);
                found      = 1'b1;
            end
        end
    endfunction

    always_comb begin
        lane_sel    = lowest_set(pending_r);
        lane_addr   = base_r + (32'(lane_sel) << 2);
        is_local    = (lane_addr >> (dmem_addr_width_lp + 2)) == 32'd0;
        pending_clr = pending_r & ~(lanes_p'(1) << lane_sel);
        // Beat fields only depend on pending_r, which moves only on fire,
        // so a stalled target sees a stable beat.
        fire        = (state_r == ISSUE) && (is_local ? dmem_ready_i : remote_ready_i);
    end

    lsu_store_align align (
        .is_byte_op_i (is_byte_r),
        .is_hex_op_i  (is_hex_r),
        .byte_offset_i(lane_addr[1:0]),
        .data_i       (lane_data_r[lane_sel]),
        .data_o       (st_data),
        .mask_o       (st_mask)
    );

    always_comb begin
        beat.w       = is_store_r;
        beat.addr    = lane_addr;
        beat.data    = is_store_r ? st_data : '0;
        beat.mask    = st_mask;
        beat.lane_id = lsu_simd_lane_id_width_gp'(lane_sel);
    end

    assign unused_lane_id_hi = ^beat.lane_id;
    assign rd_o              = rd_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE:    if (v_i) state_n = (lane_en_i != '0) ? ISSUE : DONE;
            ISSUE:   if (fire && (pending_clr == '0)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ready_o       = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        dmem_v_o      = 1'b0;
        dmem_w_o      = 1'b0;
        dmem_addr_o   = '0;
        dmem_data_o   = '0;
        dmem_mask_o   = '0;
        remote_v_o    = 1'b0;
        remote_w_o    = 1'b0;
        remote_addr_o = '0;
        remote_data_o = '0;
        remote_mask_o = '0;
        lane_id_o     = '0;
        unique case (state_r)
            IDLE: ready_o = 1'b1;
            ISSUE: begin
                busy_o    = 1'b1;
                lane_id_o = beat.lane_id[lane_id_width_lp-1:0];
                if (is_local) begin
                    dmem_v_o    = 1'b1;
                    dmem_w_o    = beat.w;
                    dmem_addr_o = beat.addr[2 +: dmem_addr_width_lp];
                    dmem_data_o = beat.data;
                    dmem_mask_o = beat.mask;
                end else begin
                    remote_v_o    = 1'b1;
                    remote_w_o    = beat.w;
                    remote_addr_o = beat.addr;
                    remote_data_o = beat.data;
                    remote_mask_o = beat.mask;
                end
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_r     <= '0;
            is_store_r <= 1'b0;
            is_byte_r  <= 1'b0;
            is_hex_r   <= 1'b0;
            rd_r       <= '0;
            pending_r  <= '0;
            for (int unsigned i = 0; i < lanes_p; i++) lane_data_r[i] <= '0;
        end else if ((state_r == IDLE) && v_i) begin
            base_r     <= rs1_i + {{20{offset_i[11]}}, offset_i};
            is_store_r <= is_store_i;
            is_byte_r  <= is_byte_op_i;
            is_hex_r   <= is_hex_op_i & ~is_byte_op_i;
            rd_r       <= rd_i;
            pending_r  <= lane_en_i;
            for (int unsigned i = 0; i < lanes_p; i++)
                lane_data_r[i] <= data_i[i*data_width_p +: data_width_p];
        end else if (fire) begin
            pending_r <= pending_clr;
        end
    end

    // Byte and halfword together is an illegal encoding; byte still wins.
    assert property (@(posedge clk_i) disable iff (reset_i)
                     (v_i && ready_o) |-> !(is_byte_op_i && is_hex_op_i))
        else $error("lsu_simd_seq: byte and hex op both set");

endmodule
